// File: rtl/pong_motion_ctrl.sv
// Per-frame game controller: moves the ball and paddles from the detector flags,
// keeps score and sequences idle / serve / play / game-over.
module pong_motion_ctrl #(
  parameter int unsigned BALL_SPEED   = 2,
  parameter int unsigned PADDLE_SPEED = 4,
  parameter int unsigned SERVE_DELAY  = 60,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        serve,
  input  logic        btn_R_up,
  input  logic        btn_R_dn,
  input  logic        btn_L_up,
  input  logic        btn_L_dn,
  input  logic [3:0]  ball_detect_edge,
  input  logic [3:0]  paddle_R_detect_edge,
  input  logic [3:0]  paddle_L_detect_edge,
  input  logic [7:0]  collision_detect,
  output logic [31:0] ball_off_x,
  output logic [31:0] ball_off_y,
  output logic [31:0] paddle_R_off_y,
  output logic [31:0] paddle_L_off_y,
  output logic [3:0]  score_L,
  output logic [3:0]  score_R,
  output logic [1:0]  game_state
);

  localparam logic [31:0] BallStep  = 32'(BALL_SPEED);
  localparam logic [31:0] PadStep   = 32'(PADDLE_SPEED);
  localparam logic [31:0] ServeLoad = 32'(SERVE_DELAY - 1);
  localparam logic [3:0]  WinScore  = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StServeWait = 2'd1,
    StPlay      = 2'd2,
    StGameOver  = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] cnt_q;
  logic        dir_x_q, dir_y_q;  // 1 = positive (right / down)
  logic [31:0] ball_x_q, ball_y_q, pad_r_q, pad_l_q;
  logic [3:0]  score_l_q, score_r_q;

  logic        hit_r, hit_l, miss_l, miss_r, pad_move;
  logic        dir_x_nxt, dir_y_nxt;
  logic [31:0] ball_x_nxt, ball_y_nxt, pad_r_nxt, pad_l_nxt;
  logic [3:0]  score_l_inc, score_r_inc;

  // Bits of the detector buses that this controller has no use for.
  logic unused_flags;
  assign unused_flags = ^{collision_detect[7:6], collision_detect[4:3],
                          paddle_R_detect_edge[3], paddle_R_detect_edge[1],
                          paddle_L_detect_edge[3], paddle_L_detect_edge[1]};

  assign hit_r       = collision_detect[0] & collision_detect[2];
  assign hit_l       = collision_detect[1] & collision_detect[5];
  assign miss_l      = ~ball_detect_edge[3] & ~hit_l;
  assign miss_r      = ~ball_detect_edge[1] & ~hit_r;
  assign score_l_inc = score_l_q + 4'd1;
  assign score_r_inc = score_r_q + 4'd1;
  assign pad_move    = (state_q == StServeWait) || (state_q == StPlay);

  // Directions are forced by the surface touched, never toggled.
  always_comb begin
    dir_x_nxt = dir_x_q;
    if (hit_r && !hit_l)      dir_x_nxt = 1'b0;
    else if (hit_l && !hit_r) dir_x_nxt = 1'b1;
    dir_y_nxt = dir_y_q;
    if (!ball_detect_edge[2]) dir_y_nxt = 1'b1;
    if (!ball_detect_edge[0]) dir_y_nxt = 1'b0;
    ball_x_nxt = dir_x_nxt ? ball_x_q + BallStep : ball_x_q - BallStep;
    ball_y_nxt = dir_y_nxt ? ball_y_q + BallStep : ball_y_q - BallStep;
  end

  always_comb begin
    pad_r_nxt = pad_r_q;
    if (btn_R_up && !btn_R_dn && paddle_R_detect_edge[2])      pad_r_nxt = pad_r_q - PadStep;
    else if (btn_R_dn && !btn_R_up && paddle_R_detect_edge[0]) pad_r_nxt = pad_r_q + PadStep;
    pad_l_nxt = pad_l_q;
    if (btn_L_up && !btn_L_dn && paddle_L_detect_edge[2])      pad_l_nxt = pad_l_q - PadStep;
    else if (btn_L_dn && !btn_L_up && paddle_L_detect_edge[0]) pad_l_nxt = pad_l_q + PadStep;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      ball_x_q  <= '0;
      ball_y_q  <= '0;
      pad_r_q   <= '0;
      pad_l_q   <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
    end else if (frame_tick) begin
      if (pad_move) begin
        pad_r_q <= pad_r_nxt;
        pad_l_q <= pad_l_nxt;
      end
      unique case (state_q)
        StIdle: begin
          if (serve) begin
            state_q <= StServeWait;
            cnt_q   <= ServeLoad;
          end
        end
        StServeWait: begin
          if (cnt_q == '0) state_q <= StPlay;
          else             cnt_q   <= cnt_q - 32'd1;
        end
        StPlay: begin
          if (miss_l) begin
            score_r_q <= score_r_inc;
            ball_x_q  <= '0;
            ball_y_q  <= '0;
            dir_x_q   <= 1'b0;
            cnt_q     <= ServeLoad;
            state_q   <= (score_r_inc == WinScore) ? StGameOver : StServeWait;
          end else if (miss_r) begin
            score_l_q <= score_l_inc;
            ball_x_q  <= '0;
            ball_y_q  <= '0;
            dir_x_q   <= 1'b1;
            cnt_q     <= ServeLoad;
            state_q   <= (score_l_inc == WinScore) ? StGameOver : StServeWait;
          end else begin
            dir_x_q  <= dir_x_nxt;
            dir_y_q  <= dir_y_nxt;
            ball_x_q <= ball_x_nxt;
            ball_y_q <= ball_y_nxt;
          end
        end
        StGameOver: begin
          if (serve) begin
            score_l_q <= '0;
            score_r_q <= '0;
            ball_x_q  <= '0;
            ball_y_q  <= '0;
            pad_r_q   <= '0;
            pad_l_q   <= '0;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            cnt_q     <= ServeLoad;
            state_q   <= StServeWait;
          end
        end
        default: ;
      endcase
    end
  end

  assign ball_off_x     = ball_x_q;
  assign ball_off_y     = ball_y_q;
  assign paddle_R_off_y = pad_r_q;
  assign paddle_L_off_y = pad_l_q;
  assign score_L        = score_l_q;
  assign score_R        = score_r_q;
  assign game_state     = state_q;

endmodule

// File: tb/tb_pong_motion_ctrl.sv
// Scoreboard bench for pong_motion_ctrl: directed frame vectors push hand-computed
// expectations; a monitor pops them after each tick/reset and checks holds in between.
module tb_pong_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0, frame_tick = 1'b0, serve = 1'b0;
  logic        btn_R_up = 1'b0, btn_R_dn = 1'b0, btn_L_up = 1'b0, btn_L_dn = 1'b0;
  logic [3:0]  ball_detect_edge = 4'hF, paddle_R_detect_edge = 4'hF;
  logic [3:0]  paddle_L_detect_edge = 4'hF;
  logic [7:0]  collision_detect = 8'h00;
  logic [31:0] ball_off_x, ball_off_y, paddle_R_off_y, paddle_L_off_y;
  logic [3:0]  score_L, score_R;
  logic [1:0]  game_state;

  always #5 clk = ~clk;

  pong_motion_ctrl #(
    .BALL_SPEED  (2),
    .PADDLE_SPEED(4),
    .SERVE_DELAY (3),
    .WIN_SCORE   (2)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .frame_tick          (frame_tick),
    .serve               (serve),
    .btn_R_up            (btn_R_up),
    .btn_R_dn            (btn_R_dn),
    .btn_L_up            (btn_L_up),
    .btn_L_dn            (btn_L_dn),
    .ball_detect_edge    (ball_detect_edge),
    .paddle_R_detect_edge(paddle_R_detect_edge),
    .paddle_L_detect_edge(paddle_L_detect_edge),
    .collision_detect    (collision_detect),
    .ball_off_x          (ball_off_x),
    .ball_off_y          (ball_off_y),
    .paddle_R_off_y      (paddle_R_off_y),
    .paddle_L_off_y      (paddle_L_off_y),
    .score_L             (score_L),
    .score_R             (score_R),
    .game_state          (game_state)
  );

  typedef struct packed {
    logic [31:0] bx, by, pr, pl;
    logic [3:0]  sl, sr;
    logic [1:0]  gs;
  } exp_t;

  localparam logic [31:0] M2 = 32'hFFFF_FFFE, M4 = 32'hFFFF_FFFC, M6 = 32'hFFFF_FFFA;
  localparam logic [31:0] M8 = 32'hFFFF_FFF8, M10 = 32'hFFFF_FFF6;

  exp_t q[$];
  exp_t last_exp;
  bit   armed = 1'b0;
  int   checks = 0, errors = 0;

  function automatic exp_t ex(input logic [31:0] bx, by, pr, pl,
                              input logic [3:0] sl, sr, input logic [1:0] gs);
    exp_t e;
    e.bx = bx; e.by = by; e.pr = pr; e.pl = pl; e.sl = sl; e.sr = sr; e.gs = gs;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".ball_off_x"}, ball_off_x, e.bx);
    chk({tag, ".ball_off_y"}, ball_off_y, e.by);
    chk({tag, ".paddle_R_off_y"}, paddle_R_off_y, e.pr);
    chk({tag, ".paddle_L_off_y"}, paddle_L_off_y, e.pl);
    chk({tag, ".score_L"}, {28'd0, score_L}, {28'd0, e.sl});
    chk({tag, ".score_R"}, {28'd0, score_R}, {28'd0, e.sr});
    chk({tag, ".game_state"}, {30'd0, game_state}, {30'd0, e.gs});
  endtask

  // Monitor: after every tick/reset edge pop and compare; otherwise outputs must hold.
  initial begin
    forever begin
      @(posedge clk);
      if (rst || frame_tick) begin
        #1;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: update with no expectation queued at %0t", $time);
        end else begin
          last_exp = q.pop_front();
          armed    = 1'b1;
          chk_all("update", last_exp);
        end
      end else if (armed) begin
        #1;
        chk_all("hold", last_exp);
      end
    end
  end

  task automatic step(input logic r, input logic t, input logic s, input logic [3:0] be,
                      input logic [7:0] cd, input logic [3:0] btn, input logic [3:0] per,
                      input logic [3:0] pel, input exp_t e);
    @(negedge clk);
    rst = r; frame_tick = t; serve = s;
    ball_detect_edge = be; collision_detect = cd;
    {btn_R_up, btn_R_dn, btn_L_up, btn_L_dn} = btn;
    paddle_R_detect_edge = per; paddle_L_detect_edge = pel;
    if (r || t) q.push_back(e);
    @(negedge clk);
    rst = 1'b0; frame_tick = 1'b0;
  endtask

  // btn = {R_up, R_dn, L_up, L_dn}
  task automatic tk(input logic s, input logic [3:0] be, input logic [7:0] cd,
                    input logic [3:0] btn, input logic [3:0] per, input logic [3:0] pel,
                    input exp_t e);
    step(1'b0, 1'b1, s, be, cd, btn, per, pel, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    z = ex(0, 0, 0, 0, 0, 0, 0);
    // Reset, then idle with serve low and a paddle button held.
    step(1, 0, 0, 4'hF, 8'h00, 4'b0000, 4'hF, 4'hF, z);
    step(1, 0, 0, 4'hF, 8'h00, 4'b0000, 4'hF, 4'hF, z);
    for (int i = 0; i < 10; i++) tk(0, 4'hF, 8'h00, 4'b1000, 4'hF, 4'hF, z);
    // Serve delay of 3: PLAY on the 4th tick, first ball step on the 5th.
    tk(1, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(0, 0, 0, 0, 0, 0, 1));
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(0, 0, 0, 0, 0, 0, 1));
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(0, 0, 0, 0, 0, 0, 1));
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(0, 0, 0, 0, 0, 0, 2));
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(2, 2, 0, 0, 0, 0, 2));
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(4, 4, 0, 0, 0, 0, 2));
    // Bottom bounce, then right paddle hit, then wrap below zero.
    tk(0, 4'hE, 8'h00, 0, 4'hF, 4'hF, ex(6, 2, 0, 0, 0, 0, 2));
    tk(0, 4'hF, 8'h05, 0, 4'hF, 4'hF, ex(4, 0, 0, 0, 0, 0, 2));
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(2, M2, 0, 0, 0, 0, 2));
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(0, M4, 0, 0, 0, 0, 2));
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(M2, M6, 0, 0, 0, 0, 2));
    // Left wall but saved by the L paddle: no score, dir_x forced right.
    tk(0, 4'h7, 8'h22, 0, 4'hF, 4'hF, ex(0, M8, 0, 0, 0, 0, 2));
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(2, M10, 0, 0, 0, 0, 2));
    // Both paddle hits keep dir_x; top edge together with them flips dir_y down.
    tk(0, 4'hB, 8'h27, 0, 4'hF, 4'hF, ex(4, M8, 0, 0, 0, 0, 2));
    // Right-wall miss scores for L.
    tk(0, 4'hD, 8'h00, 0, 4'hF, 4'hF, ex(0, 0, 0, 0, 1, 0, 1));
    // Paddles in SERVE_WAIT: free move, blocked at edges, both buttons; serve ignored.
    tk(0, 4'hF, 8'h00, 4'b1001, 4'hF, 4'hF, ex(0, 0, M4, 4, 1, 0, 1));
    tk(1, 4'hF, 8'h00, 4'b1001, 4'hB, 4'hE, ex(0, 0, M4, 4, 1, 0, 1));
    tk(0, 4'hF, 8'h00, 4'b1100, 4'hF, 4'hF, ex(0, 0, M4, 4, 1, 0, 2));
    // Left-wall miss scores for R; next serve goes left.
    tk(0, 4'h7, 8'h00, 0, 4'hF, 4'hF, ex(0, 0, M4, 4, 1, 1, 1));
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(0, 0, M4, 4, 1, 1, 1));
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(0, 0, M4, 4, 1, 1, 1));
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(0, 0, M4, 4, 1, 1, 2));
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(M2, 2, M4, 4, 1, 1, 2));
    // Second R point reaches WIN_SCORE=2.
    tk(0, 4'h7, 8'h00, 0, 4'hF, 4'hF, ex(0, 0, M4, 4, 1, 2, 3));
    // GAME_OVER: paddles frozen, no further scoring.
    tk(0, 4'h7, 8'h00, 4'b0110, 4'hF, 4'hF, ex(0, 0, M4, 4, 1, 2, 3));
    tk(0, 4'h7, 8'h00, 4'b0110, 4'hF, 4'hF, ex(0, 0, M4, 4, 1, 2, 3));
    // New game clears everything.
    tk(1, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(0, 0, 0, 0, 0, 0, 1));
    tk(0, 4'hF, 8'h00, 4'b0010, 4'hF, 4'hF, ex(0, 0, 0, M4, 0, 0, 1));
    // Reset mid-serve without a tick, then reset winning over a serve tick.
    step(1, 0, 0, 4'hF, 8'h00, 0, 4'hF, 4'hF, z);
    step(1, 1, 1, 4'hF, 8'h00, 0, 4'hF, 4'hF, z);
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, z);
    // Directions are back to (+1,+1) after reset.
    tk(1, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(0, 0, 0, 0, 0, 0, 1));
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(0, 0, 0, 0, 0, 0, 1));
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(0, 0, 0, 0, 0, 0, 1));
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(0, 0, 0, 0, 0, 0, 2));
    tk(0, 4'hF, 8'h00, 0, 4'hF, 4'hF, ex(2, 2, 0, 0, 0, 0, 2));

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_motion_ctrl.md
# pong_motion_ctrl

Sequential game controller that closes the loop around the combinational edge/collision detector. Once per video frame it consumes the detector's edge and collision flags plus the player buttons. It then updates the ball and paddle offsets, which feed back into the detector and the renderer. It also keeps score and sequences the serve / play / game-over flow.

## Interface
Parameters:
- BALL_SPEED, 2: ball step per frame on each axis, in pixels (1..15).
- PADDLE_SPEED, 4: paddle step per frame, in pixels (1..15).
- SERVE_DELAY, 60: frames between a serve request or point and ball motion (must be ≥1).
- WIN_SCORE, 9: score that ends the game (1..15).

Ports:
- clk, in, 1: the block's single clock.
- rst, in, 1: synchronous, active-high reset.
- frame_tick, in, 1: one-cycle pulse per frame (vsync-derived); every high cycle counts as one frame.
- serve, in, 1: level, sampled only on frame_tick.
- btn_R_up, btn_R_dn, btn_L_up, btn_L_dn, in, 1 each: paddle buttons, active-high levels.
- ball_detect_edge, in, 4: active-low; [0]=bottom, [1]=right wall, [2]=top, [3]=left wall.
- paddle_R_detect_edge, paddle_L_detect_edge, in, 4: same bit meaning as ball_detect_edge.
- collision_detect, in, 8:
  - [0]: ball x reaches the R paddle.
  - [1]: ball x reaches the L paddle.
  - [2]: ball y overlaps the R paddle.
  - [5]: ball y overlaps the L paddle.
  - Other bits are ignored.
- ball_off_x, ball_off_y, out, 32: ball offsets, two's complement.
- paddle_R_off_y, paddle_L_off_y, out, 32: paddle vertical offsets, two's complement.
- score_L, score_R, out, 4: player scores.
- game_state, out, 2: 0=IDLE, 1=SERVE_WAIT, 2=PLAY, 3=GAME_OVER.

## Operation
- Reset: rst has priority over all other inputs in every state. It drives:
  - All offsets to 0.
  - Both scores to 0.
  - game_state to IDLE.
  - dir_x and dir_y to +1 (right, down).
  - Serve counter to 0.
- Offset arithmetic is 32-bit modulo 2^32; a step is offset ± speed, zero-extended from the parameter. Nothing else happens to the sum, and downstream adds it to the initial position.
- All state updates happen only on cycles where frame_tick=1. On other cycles every register holds its value.
- IDLE: the ball offsets stay 0. serve=1 → SERVE_WAIT, and the counter loads SERVE_DELAY-1.
- SERVE_WAIT: on each tick, if counter==0 → PLAY; otherwise counter decrements. PLAY is therefore entered on the SERVE_DELAY-th tick. The ball does not move on that tick.
- PLAY: on each tick, evaluate the flags in the order below.
  1. hit_R = collision_detect[0] & collision_detect[2].
  2. hit_L = collision_detect[1] & collision_detect[5].
  3. Left-wall score: ball_detect_edge[3]==0 and !hit_L. Then:
     - score_R increments.
     - Ball offsets are set to 0.
     - dir_x is set to -1 (serve toward the loser).
  4. Right-wall score, mirrored: ball_detect_edge[1]==0 and !hit_R. Then score_L increments, ball offsets are set to 0, dir_x is set to +1.
  5. After a score: if the new score == WIN_SCORE → GAME_OVER; otherwise → SERVE_WAIT with the counter reloaded. There is no ball step on a scoring tick.
  6. Otherwise, directions are forced, never toggled, so the ball cannot stick against a surface:
     - hit_R sets dir_x = -1.
     - hit_L sets dir_x = +1.
     - ball_detect_edge[2]==0 sets dir_y = +1.
     - ball_detect_edge[0]==0 sets dir_y = -1.
  7. The ball then steps by BALL_SPEED on each axis using the updated dir_x and dir_y.
- Simultaneous events within one tick:
  - Paddle hit together with a top/bottom edge: both direction updates apply.
  - hit_R and hit_L together: dir_x is left unchanged.
  - Edge flags are consumed exactly as presented by the detector, which prioritises bottom over right over top over left.
- Paddles move in SERVE_WAIT and PLAY only:
  - up alone: the paddle steps -PADDLE_SPEED unless its edge bit [2]==0.
  - dn alone: the paddle steps +PADDLE_SPEED unless its edge bit [0]==0.
  - Both buttons or neither: no move.
  - Paddles hold their offsets in IDLE and GAME_OVER.
- GAME_OVER: serve=1 on a tick clears both scores, the ball offsets, and both paddle offsets, resets dir_x and dir_y to +1, and enters SERVE_WAIT with the counter loaded.
- serve is ignored in SERVE_WAIT and PLAY.

## Timing
- All outputs are registered. An update appears on the cycle after the frame_tick cycle that caused it, so the latency is 1 clk.
- Flags are combinational functions of the current registered offsets. A decision on a tick therefore uses the offsets from the previous frame.
- No output changes while frame_tick=0 unless rst=1.
- rst asserted mid-frame or mid-serve takes effect on the next clk edge. No pending step survives reset.
- Scores never exceed WIN_SCORE. No increment occurs outside PLAY.

## Test plan
- Reset/IDLE: assert rst for 2 cycles, then 10 ticks with serve=0 → all offsets 0, scores 0, game_state=0 throughout.
- Serve delay: SERVE_DELAY=3, serve=1 on tick 1 → game_state=1 after tick 1 and =2 after tick 4. ball_off_x/ball_off_y first become 2/2 after tick 5.
- Bounce: in PLAY with dir=(+1,+1), drive ball_detect_edge=4'b1110 for one tick → ball_off_y decreases by 2 on that tick. Then drive collision_detect=8'h05 → ball_off_x decreases by 2 (wraps to 0xFFFF_FFFE from 0).
- Miss: ball_detect_edge=4'b0111 with collision_detect=0 → score_R +1, ball offsets 0, game_state=1. The same stimulus with collision_detect=8'h22 → no score, dir_x=+1.
- Paddle limits: btn_R_up held and paddle_R_detect_edge=4'b1011 → paddle_R_off_y unchanged. With edge=4'hF it changes by -4 per tick. btn_R_up and btn_R_dn together → no change.
- Game over: WIN_SCORE=2, two left-wall misses → score_R=2, game_state=3, paddles frozen. A subsequent serve tick → scores 0, game_state=1. rst asserted during SERVE_WAIT → state 0 on the next clk.
